reg_dump: RTL and testbench

Register-file readback engine for the RISC-V core. On a start pulse it walks a contiguous, optionally wrapping, range of architectural registers through one register-file read port. Each value goes out on a valid/ready stream tagged with its register index, for debug and trace export and for testbench end-of-run state checks. It is the reader counterpart to the register-file write port: it only issues read addresses and consumes combinational read data.

---
 rtl/reg_dump.sv | 96 +++++++++
 tb/tb_reg_dump.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// Register-file readback engine: walks a wrapping index range through one
// combinational read port and streams each value out tagged with its index.
module reg_dump #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] first_addr,
    input  logic [ADDRESS_WIDTH-1:0] last_addr,
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [ADDRESS_WIDTH-1:0] out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    // state | meaning
    // IDLE  | waiting for start, read port parked at 0
    // LOAD  | first word read from cur into the output register
    // SEND  | word pending; next index pre-read so handshakes run back-to-back
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] cur;
    logic [ADDRESS_WIDTH-1:0] end_q;
    logic [ADDRESS_WIDTH-1:0] cur_inc;

    assign cur_inc  = cur + ONE;
    assign busy     = (state != IDLE);
    assign out_last = (state == SEND) && (out_index == end_q);

    always_comb begin
        rd_addr = '0;
        case (state)
            LOAD:    rd_addr = cur;
            SEND:    rd_addr = cur_inc;
            default: rd_addr = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            end_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur   <= first_addr;
                        end_q <= last_addr;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    out_data  <= rd_data;
                    out_index <= cur;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        if (cur != end_q) begin
                            cur       <= cur_inc;
                            out_data  <= rd_data;
                            out_index <= cur_inc;
                        end else begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: a register-file model feeds rd_data and a
// scoreboard of expected words is drained by a stream monitor.
module tb_reg_dump;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [32];

    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];

    reg_dump #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .busy(busy), .done(done)
    );

    task step();
        @(posedge clk);
        #1;
    endtask

    task push_range(input logic [AW-1:0] f, input logic [AW-1:0] l);
        logic [AW-1:0] d;
        logic [AW-1:0] a;
        exp_t          e;
        int            n;
        d = l - f;
        n = int'(d) + 1;
        a = f;
        for (int k = 0; k < n; k++) begin
            e.idx  = a;
            e.data = regs[a];
            e.last = (k == n - 1);
            sb.push_back(e);
            a = a + 5'd1;
        end
    endtask

    // Leaves the bench in cycle 1 (the edge sampling start is edge 0).
    task start_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
        push_range(f, l);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        step();
        start = 1'b0;
    endtask

    task monitor();
        logic          hold;
        logic [DW-1:0] hd;
        logic [AW-1:0] hi;
        exp_t          e;
        hold = 1'b0;
        hd   = '0;
        hi   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                checks++;
                if (done && busy) begin
                    errors++;
                    $display("FAIL done_with_busy: done=%b busy=%b, required not both high", done, busy);
                end
                if (hold) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== hd || out_index !== hi) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%b data=%h index=%0d, required valid=1 data=%h index=%0d",
                                 out_valid, out_data, out_index, hd, hi);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word: index=%0d data=%h, required no word", out_index, out_data);
                    end else begin
                        e = sb.pop_front();
                        if (out_index !== e.idx || out_data !== e.data || out_last !== e.last) begin
                            errors++;
                            $display("FAIL stream_word: index=%0d data=%h last=%b, required index=%0d data=%h last=%b",
                                     out_index, out_data, out_last, e.idx, e.data, e.last);
                        end
                    end
                end
                hold = out_valid && !out_ready;
                hd   = out_data;
                hi   = out_index;
            end
        end
    endtask

    task test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; first_addr = '0; last_addr = '0;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b required 0", out_last); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (out_data !== '0 || out_index !== '0) begin errors++; $display("FAIL reset_outputs: data=%h index=%0d required 0", out_data, out_index); end
        checks++; if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %0d required 0", rd_addr); end
        rst = 1'b0;
        step();
    endtask

    task test_full();
        out_ready = 1'b1;
        start_dump(5'd0, 5'd31);
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL full_cycle1: busy=%b valid=%b required busy=1 valid=0", busy, out_valid); end
        for (int c = 2; c <= 33; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_index !== AW'(c - 2)) begin
                errors++;
                $display("FAIL full_timing: cycle %0d valid=%b index=%0d required valid=1 index=%0d", c, out_valid, out_index, c - 2);
            end
        end
        step();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL full_done: cycle 34 done=%b busy=%b required done=1 busy=0", done, busy); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_pulse: got %b required 0", done); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL full_drain: %0d words left, required 0", sb.size()); end
    endtask

    task test_single();
        out_ready = 1'b1;
        start_dump(5'd5, 5'd5);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b1 || out_index !== 5'd5 || out_data !== 32'h105) begin
            errors++;
            $display("FAIL single_word: valid=%b last=%b index=%0d data=%h required 1 1 5 00000105", out_valid, out_last, out_index, out_data);
        end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: cycle 3 done=%b required 1", done); end
        step();
    endtask

    task test_wrap();
        out_ready = 1'b1;
        start_dump(5'd30, 5'd1);
        for (int i = 0; i < 100; i++) begin
            step();
            if (done) break;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b required 1", done); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d words left, required 0", sb.size()); end
        step();
    endtask

    task test_backpressure();
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        out_ready = 1'b1;
        start_dump(5'd0, 5'd7);
        for (int i = 0; i < 200; i++) begin
            out_ready = pat[i % 4];
            step();
            if (done) break;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b required 1", done); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: %0d words left, required 0", sb.size()); end
        out_ready = 1'b1;
        step();
    endtask

    task test_write_restart();
        exp_t e;
        int   done_cnt;
        out_ready = 1'b1;
        start_dump(5'd0, 5'd9);
        e = sb[6]; e.data = 32'h0000DEAD; sb[6] = e;
        done_cnt = 0;
        for (int c = 2; c <= 45; c++) begin
            step();
            if (c == 4) begin
                start = 1'b1; first_addr = 5'd20; last_addr = 5'd25;
            end else begin
                start = 1'b0;
            end
            if (c == 6) begin
                checks++; if (out_index !== 5'd4) begin errors++; $display("FAIL wr_position: index=%0d required 4", out_index); end
                regs[6] = 32'h0000DEAD;
                regs[4] = 32'h0000BEEF;
            end
            if (done) done_cnt++;
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL wr_done_count: got %0d required 1", done_cnt); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL wr_drain: %0d words left, required 0", sb.size()); end
        regs[4] = 32'h104;
        regs[6] = 32'h106;
    endtask

    task test_reset_abort();
        out_ready = 1'b1;
        start_dump(5'd0, 5'd31);
        repeat (4) step();
        checks++; if (out_index !== 5'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL abort_position: index=%0d valid=%b required 3 1", out_index, out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b required 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b required 0", done); end
        sb.delete();
        step();
        rst = 1'b0;
        step();
        start_dump(5'd7, 5'd8);
        step();
        checks++;
        if (out_valid !== 1'b1 || out_index !== 5'd7 || out_data !== 32'h107) begin
            errors++;
            $display("FAIL restart_first: valid=%b index=%0d data=%h required 1 7 00000107", out_valid, out_index, out_data);
        end
        for (int i = 0; i < 50; i++) begin
            step();
            if (done) break;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b required 1", done); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL restart_drain: %0d words left, required 0", sb.size()); end
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; first_addr = '0; last_addr = '0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
        fork
            monitor();
        join_none
        test_reset();
        test_full();
        test_single();
        test_wrap();
        test_backpressure();
        test_write_restart();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
